// File: rtl/trng_post_proc.sv
// rtl/trng_post_proc.sv - TRNG post-processing: warm-up, von Neumann corrector, word packing, valid/ready output.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_TEST_EN.
module trng_post_proc #(
    parameter int LFSR_W    = 10,
    parameter int TAP       = 0,
    parameter int OUT_W     = 32,
    parameter int WARMUP    = 64,
    parameter int RCT_LIMIT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [LFSR_W-1:0] lfsr_data,
    output logic              lfsr_en,
    output logic [OUT_W-1:0]  rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              rnd_fail,
    input  logic              fail_clr
);

    localparam int WCW = $clog2(WARMUP + 1);
    localparam int BCW = $clog2(OUT_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_HOLD,
        S_FAIL
    } state_t;

    state_t           state, state_nx;
    logic [WCW-1:0]   warm_cnt, warm_cnt_nx;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nx;
    logic             phase, phase_nx;
    logic             first_bit, first_bit_nx;
    logic [OUT_W-1:0] acc, acc_nx;
    logic [OUT_W-1:0] data_q, data_nx;
    logic             valid_q, valid_nx;
    logic             sample;
    logic [OUT_W-1:0] acc_shift;
    logic             rct_trip;
    logic             unused_lfsr_bits;

    assign sample           = lfsr_data[TAP];
    assign acc_shift        = {acc[OUT_W-2:0], first_bit};
    assign unused_lfsr_bits = ^lfsr_data;

    assign lfsr_en   = (state == S_WARMUP) || (state == S_COLLECT);
    assign rnd_data  = data_q;
    assign rnd_valid = valid_q;

`ifdef TRNG_HEALTH_TEST_EN
    localparam int RCW = $clog2(RCT_LIMIT + 1);

    logic [RCW-1:0] run_cnt, run_cnt_nx;
    logic           prev_bit;

    // run_cnt of 0 marks the first sample after entering COLLECT
    always_comb begin
        run_cnt_nx = '0;
        rct_trip   = 1'b0;
        if (state == S_COLLECT) begin
            if (run_cnt == '0 || sample != prev_bit) begin
                run_cnt_nx = RCW'(1);
            end else begin
                run_cnt_nx = run_cnt + 1'b1;
            end
            rct_trip = (run_cnt_nx == RCW'(RCT_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            prev_bit <= 1'b0;
        end else begin
            run_cnt <= run_cnt_nx;
            if (state == S_COLLECT) begin
                prev_bit <= sample;
            end
        end
    end

    assign rnd_fail = (state == S_FAIL);
`else
    assign rct_trip = 1'b0;
    assign rnd_fail = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        warm_cnt_nx  = warm_cnt;
        bit_cnt_nx   = bit_cnt;
        phase_nx     = phase;
        first_bit_nx = first_bit;
        acc_nx       = acc;
        data_nx      = data_q;
        valid_nx     = valid_q & ~rnd_ready;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nx    = S_WARMUP;
                    warm_cnt_nx = '0;
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (warm_cnt == WCW'(WARMUP - 1)) begin
                    state_nx   = S_COLLECT;
                    phase_nx   = 1'b0;
                    bit_cnt_nx = '0;
                    acc_nx     = '0;
                end else begin
                    warm_cnt_nx = warm_cnt + 1'b1;
                end
            end
            S_COLLECT: begin
                if (rct_trip) begin
                    state_nx = S_FAIL;
                    valid_nx = 1'b0;
                end else if (!enable) begin
                    state_nx = S_IDLE;
                end else if (!phase) begin
                    first_bit_nx = sample;
                    phase_nx     = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    if (first_bit != sample) begin
                        acc_nx = acc_shift;
                        if (bit_cnt == BCW'(OUT_W - 1)) begin
                            bit_cnt_nx = '0;
                            // load straight to the output if the slot is free or drains this edge
                            if (!valid_q || rnd_ready) begin
                                data_nx  = acc_shift;
                                valid_nx = 1'b1;
                            end else begin
                                state_nx = S_HOLD;
                            end
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (rnd_ready) begin
                    data_nx  = acc;
                    valid_nx = 1'b1;
                    state_nx = S_COLLECT;
                    phase_nx = 1'b0;
                    acc_nx   = '0;
                end
            end
            S_FAIL: begin
                valid_nx = 1'b0;
                if (fail_clr) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            warm_cnt  <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            first_bit <= 1'b0;
            acc       <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            warm_cnt  <= warm_cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            phase     <= phase_nx;
            first_bit <= first_bit_nx;
            acc       <= acc_nx;
            data_q    <= data_nx;
            valid_q   <= valid_nx;
        end
    end

endmodule
